fp_accum_seq: RTL and testbench

Sequential accumulation controller that sums a stream of IEEE-754 single-precision values using the combinational `fp_adder`. It sits on both sides of the adder. Upstream, it registers the running sum and the next input word and drives `operandX`/`operandY`. Downstream, it captures `result` at the next clock edge. It adds valid/ready handshakes, a programmable element count and sticky NaN/Inf status on top of the adder.

---
 rtl/fp_accum_seq.sv | 137 +++++++++++++
 tb/tb_fp_accum_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_accum_seq.sv
// Sequential IEEE-754 single accumulator wrapped around an external fp_adder.
// Handshaked input stream, programmable length, sticky NaN/Inf status.
module fp_accum_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic [31:0]      add_x,
    output logic [31:0]      add_y,
    input  logic [31:0]      add_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [LEN_W-1:0] out_count,
    output logic             flag_nan,
    output logic             flag_inf,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_ADD,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [31:0]      r_acc;
    logic [31:0]      r_opnd;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] r_cnt;
    logic [31:0]      r_sum;
    logic [LEN_W-1:0] r_ocnt;
    logic             r_nan;
    logic             r_inf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic             w_exp_max;
    logic             w_man_nz;
    logic             w_in_add;
    logic [LEN_W-1:0] w_cnt_nxt;

    assign w_exp_max = &add_result[30:23];
    assign w_man_nz  = |add_result[22:0];
    assign w_in_add  = (r_state == S_ADD);
    assign w_cnt_nxt = r_cnt + 1'b1;

    // Adder operands are muxed straight from registers so they are stable all of ADD
    assign add_x     = w_in_add ? r_acc  : 32'h0;
    assign add_y     = w_in_add ? r_opnd : 32'h0;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_count = r_ocnt;
    assign flag_nan  = r_nan;
    assign flag_inf  = r_inf;
    assign busy      = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_ocnt      <= '0;
            r_nan       <= 1'b0;
            r_inf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        r_nan  <= 1'b0;
                        r_inf  <= 1'b0;
                        r_busy <= 1'b1;
                        if (length != '0) begin
                            r_rem      <= length;
                            r_in_ready <= 1'b1;
                            r_state    <= S_ACCEPT;
                        end else begin
                            r_sum       <= '0;
                            r_ocnt      <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_ACCEPT: begin
                    if (in_valid) begin
                        r_opnd     <= in_data;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_acc <= add_result;
                    r_cnt <= w_cnt_nxt;
                    r_rem <= r_rem - 1'b1;
                    r_nan <= r_nan | (w_exp_max & w_man_nz);
                    r_inf <= r_inf | (w_exp_max & ~w_man_nz);
                    if (r_rem == LEN_W'(1)) begin
                        r_sum       <= add_result;
                        r_ocnt      <= w_cnt_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= S_ACCEPT;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed bench for fp_accum_seq with a table-driven fp_adder stand-in.
// Expected sums are hand-computed IEEE-754 single results.
module tb_fp_accum_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  length;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] add_x;
    logic [31:0] add_y;
    logic [31:0] add_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [7:0]  out_count;
    logic        flag_nan;
    logic        flag_inf;
    logic        busy;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] w [0:7];
    bit          saw_ready;
    bit          both_hi;
    bit          unstable;
    bit          bad;
    int          lat;

    always #5 clk = ~clk;

    // Known single-precision sums for the vectors used here
    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] k;
        k = {x, y};
        if (x == 32'h0) return y;
        if (y == 32'h0) return x;
        case (k)
            64'h3F800000_40000000: return 32'h40400000;
            64'h40400000_40400000: return 32'h40C00000;
            64'hBF800000_3F800000: return 32'h00000000;
            64'h7F800000_FF800000: return 32'h7FC00000;
            64'h00000001_00000001: return 32'h00000002;
            64'h3F800000_3F800000: return 32'h40000000;
            64'h40000000_3F800000: return 32'h40400000;
            64'h40400000_3F800000: return 32'h40800000;
            default:               return 32'hDEADBEEF;
        endcase
    endfunction

    assign add_result = fadd(add_x, add_y);

    fp_accum_seq #(.LEN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .length     (length),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .add_x      (add_x),
        .add_y      (add_y),
        .add_result (add_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_count  (out_count),
        .flag_nan   (flag_nan),
        .flag_inf   (flag_inf),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic run_acc(input int len, input int gap, input int ostall,
                           input bit spur, output int lt);
        int          gcnt;
        int          idx;
        bit          rdy;
        logic [31:0] held;
        gcnt      = 0;
        idx       = 0;
        saw_ready = 0;
        both_hi   = 0;
        unstable  = 0;
        @(negedge clk);
        start     = 1'b1;
        length    = len[7:0];
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        lt = 1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (in_ready && out_valid) both_hi = 1;
            if (out_valid) break;
            rdy = in_ready;
            if (rdy) saw_ready = 1;
            if (spur && lt == 1) begin
                start  = 1'b1;
                length = 8'd1;
            end
            in_valid = 1'b0;
            if (rdy) begin
                if (gcnt > 0) gcnt--;
                else begin
                    in_valid = 1'b1;
                    in_data  = w[idx];
                end
            end
            @(posedge clk);
            lt++;
            if (rdy && in_valid) begin
                idx++;
                gcnt = gap;
            end
        end
        in_valid = 1'b0;
        check("out_valid_timeout", {31'b0, out_valid}, 32'd1);
        held = out_sum;
        repeat (ostall) begin
            @(posedge clk);
            @(negedge clk);
            if (out_sum !== held || !out_valid || in_ready) unstable = 1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        length    = 8'd0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_sum", out_sum, 32'h0);
        check("rst_flags", {30'b0, flag_nan, flag_inf}, 32'd0);

        // Basic sum 1+2+3
        w[0] = 32'h3F800000;
        w[1] = 32'h40000000;
        w[2] = 32'h40400000;
        run_acc(3, 0, 0, 0, lat);
        check("basic_lat", lat, 32'd7);
        check("basic_sum", out_sum, 32'h40C00000);
        check("basic_cnt", {24'b0, out_count}, 32'd3);
        check("basic_flags", {30'b0, flag_nan, flag_inf}, 32'd0);
        check("basic_idle", {30'b0, busy, out_valid}, 32'd0);

        // Cancellation with input and output stalls
        w[0] = 32'hBF800000;
        w[1] = 32'h3F800000;
        run_acc(2, 3, 4, 0, lat);
        check("cancel_lat", lat, 32'd8);
        check("cancel_sum", out_sum, 32'h00000000);
        check("cancel_cnt", {24'b0, out_count}, 32'd2);
        check("cancel_stable", {31'b0, unstable}, 32'd0);
        check("cancel_rdy_vld", {31'b0, both_hi}, 32'd0);

        // +Inf + -Inf
        w[0] = 32'h7F800000;
        w[1] = 32'hFF800000;
        run_acc(2, 0, 1, 0, lat);
        check("spec_sum", out_sum, 32'h7FC00000);
        check("spec_inf", {31'b0, flag_inf}, 32'd1);
        check("spec_nan", {31'b0, flag_nan}, 32'd1);

        // Zero length also clears the flags
        run_acc(0, 0, 0, 0, lat);
        check("zero_lat", lat, 32'd1);
        check("zero_sum", out_sum, 32'h0);
        check("zero_cnt", {24'b0, out_count}, 32'd0);
        check("zero_noready", {31'b0, saw_ready}, 32'd0);
        check("zero_flags", {30'b0, flag_nan, flag_inf}, 32'd0);

        // Subnormals, with a stray start in ACCEPT
        w[0] = 32'h00000001;
        w[1] = 32'h00000001;
        run_acc(2, 0, 0, 1, lat);
        check("sub_lat", lat, 32'd5);
        check("sub_sum", out_sum, 32'h00000002);
        check("sub_cnt", {24'b0, out_count}, 32'd2);

        // Reset while in ADD of a 5-element run
        @(negedge clk);
        start  = 1'b1;
        length = 8'd5;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("add_x", add_x, 32'h0);
        check("add_y", add_y, 32'h3F800000);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", {31'b0, in_ready}, 32'd0);
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_xy", add_x | add_y, 32'h0);
        check("mid_rst_sum", out_sum, 32'h0);
        check("mid_rst_cnt", {24'b0, out_count}, 32'd0);
        check("mid_rst_flags", {30'b0, flag_nan, flag_inf}, 32'd0);
        bad      = 0;
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || in_ready) bad = 1;
        end
        in_valid = 1'b0;
        check("mid_rst_quiet", {31'b0, bad}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
